fetch_unit: RTL and testbench

Instruction fetch stage of the pipeline: owns the program counter, issues word requests to instruction memory, buffers returned instructions, and presents them to decode as `d_inst_o`, the instruction word the control block decodes. Decode can hold the current instruction with a stall. A branch or jump resolved downstream can redirect fetch to a new PC.

---
 rtl/fetch_unit.sv | 131 +++++++++++++
 tb/tb_fetch_unit.sv | 536 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, requests instruction words and buffers them for decode.
// Define FETCH_BYPASS_EN to forward a response to decode when the buffer is empty.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IBUF_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        d_valid_o,
  output logic [31:0] d_inst_o,
  output logic [31:0] d_pc_o
);

  localparam int PW = $clog2(IBUF_DEPTH);
  localparam int CW = PW + 1;
  localparam int OW = CW + 1;
  localparam logic [OW-1:0] DEPTH = OW'(IBUF_DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    FLUSH
  } state_t;

  state_t        state_q;
  logic [31:0]   fetch_pc_q;
  logic [31:0]   rsp_pc_q;
  logic [31:0]   tgt_pc;
  logic [CW-1:0] outst_q;
  logic [CW-1:0] outst_nxt;
  logic [CW-1:0] count_q;
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] wr_ptr_q;
  logic [31:0]   data_q [IBUF_DEPTH];
  logic [31:0]   pcb_q  [IBUF_DEPTH];
  logic          buf_vld;
  logic          byp;
  logic          pop;
  logic          buf_pop;
  logic          push;
  logic          rsp_ok;
  logic          gnt_ok;
  logic [OW-1:0] occ;

  assign imem_addr_o = fetch_pc_q;
  assign tgt_pc      = {redirect_pc_i[31:2], 2'b00};

  // decode view, request gating and buffer push/pop decisions
  always_comb begin
    buf_vld = (count_q != '0);
    rsp_ok  = imem_rvalid_i && (state_q == RUN) && !redirect_i;
`ifdef FETCH_BYPASS_EN
    byp     = imem_rvalid_i && (state_q == RUN) && !buf_vld;
`else
    byp     = 1'b0;
`endif
    d_valid_o = buf_vld || byp;
    d_inst_o  = NOP;
    d_pc_o    = pcb_q[rd_ptr_q];
    if (buf_vld) begin
      d_inst_o = data_q[rd_ptr_q];
    end else if (byp) begin
      d_inst_o = imem_rdata_i;
      d_pc_o   = rsp_pc_q;
    end
    pop        = d_valid_o && !stall_i;
    buf_pop    = pop && buf_vld && !redirect_i;
    push       = rsp_ok && !(byp && !stall_i);
    occ        = {1'b0, outst_q} + {1'b0, count_q} - OW'(pop);
    imem_req_o = (state_q == RUN) && !redirect_i && (occ < DEPTH);
    gnt_ok     = imem_req_o && imem_gnt_i;
    outst_nxt  = outst_q + CW'(gnt_ok) - CW'(imem_rvalid_i);
  end

  // control state: fsm, PCs, in-flight and buffer occupancy
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= BOOT;
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      outst_q    <= '0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      outst_q <= outst_nxt;
      if (redirect_i) begin
        fetch_pc_q <= tgt_pc;
        rsp_pc_q   <= tgt_pc;
        count_q    <= '0;
        rd_ptr_q   <= '0;
        wr_ptr_q   <= '0;
        state_q    <= (outst_nxt != '0) ? FLUSH : RUN;
      end else begin
        if (gnt_ok) fetch_pc_q <= fetch_pc_q + 32'd4;
        if (rsp_ok) rsp_pc_q <= rsp_pc_q + 32'd4;
        if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
        if (buf_pop) rd_ptr_q <= rd_ptr_q + PW'(1);
        count_q <= count_q + CW'(push) - CW'(buf_pop);
        unique case (state_q)
          BOOT:    state_q <= RUN;
          FLUSH:   if (outst_nxt == '0) state_q <= RUN;
          default: state_q <= state_q;
        endcase
      end
    end
  end

  // instruction and PC storage, written at the tail
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < IBUF_DEPTH; i++) begin
        data_q[i] <= NOP;
        pcb_q[i]  <= RESET_PC;
      end
    end else if (push) begin
      data_q[wr_ptr_q] <= imem_rdata_i;
      pcb_q[wr_ptr_q]  <= rsp_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized memory/decode stimulus against an in-order
// stream model of fetch_unit.
`timescale 1ns/1ps
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int DEPTH = 2;
  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef FETCH_BYPASS_EN
  localparam int FIRST_V = 2;
  localparam bit BYP = 1'b1;
`else
  localparam int FIRST_V = 3;
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          ready;
  } pend_t;

  logic        clk = 1'b0;
  logic        rst_n_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        d_valid_o;
  logic [31:0] d_inst_o;
  logic [31:0] d_pc_o;

  fetch_unit #(
    .RESET_PC  (RESET_PC),
    .IBUF_DEPTH(DEPTH)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_gnt_i   (imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i (imem_rdata_i),
    .stall_i      (stall_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .d_valid_o    (d_valid_o),
    .d_inst_o     (d_inst_o),
    .d_pc_o       (d_pc_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;

  pend_t pending[$];
  int epoch = 0;
  int buffered = 0;
  int consumed = 0;
  int stale_drops = 0;
  int cyc = 0;
  logic [31:0] exp_pc;
  logic [31:0] exp_fetch;

  int gnt_pct = 100;
  int stall_pct = 0;
  int redir_pct = 0;
  int lat_min = 0;
  int lat_max = 0;

  logic s_req, s_gnt, s_rvalid, s_valid, s_stall, s_redir;
  logic [31:0] s_addr, s_pc, s_inst, s_tgt;
  logic prev_ok = 1'b0;
  logic prev_req, prev_gnt, prev_redir;
  logic [31:0] prev_addr;

  function automatic logic [31:0] memf(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0000_0013;
      32'h4:   return 32'h0010_0093;
      32'h8:   return 32'h0020_0113;
      default: return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endcase
  endfunction

  task automatic reset_model();
    pending.delete();
    buffered = 0;
    epoch++;
    exp_pc = RESET_PC;
    exp_fetch = RESET_PC;
    prev_ok = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i = 32'h0;
  endtask

  // One clock: sample and score at negedge, advance model at posedge, drive at +1.
  task automatic cycle();
    bit exp_v;
    pend_t e;
    @(negedge clk);
    s_req = imem_req_o;
    s_addr = imem_addr_o;
    s_gnt = imem_gnt_i;
    s_rvalid = imem_rvalid_i;
    s_valid = d_valid_o;
    s_pc = d_pc_o;
    s_inst = d_inst_o;
    s_stall = stall_i;
    s_redir = redirect_i;
    s_tgt = redirect_pc_i;
    exp_v = (buffered > 0);
    if (BYP && s_rvalid && pending.size() > 0 && pending[0].epoch == epoch)
      exp_v = 1'b1;
    n_tests++;
    if (s_valid !== exp_v) begin
      n_fail++;
      $display("FAIL d_valid @%0d: got %b expected %b", cyc, s_valid, exp_v);
    end
    if (s_valid) begin
      n_tests++;
      if (s_pc !== exp_pc || s_inst !== memf(exp_pc)) begin
        n_fail++;
        $display("FAIL stream @%0d: got pc %h inst %h expected pc %h inst %h",
                 cyc, s_pc, s_inst, exp_pc, memf(exp_pc));
      end
    end else begin
      n_tests++;
      if (s_inst !== NOP) begin
        n_fail++;
        $display("FAIL idle_nop @%0d: got %h expected %h", cyc, s_inst, NOP);
      end
    end
    n_tests++;
    if (s_addr[1:0] !== 2'b00) begin
      n_fail++;
      $display("FAIL addr_align @%0d: got %h expected low bits 00", cyc, s_addr);
    end
    if (s_req && s_gnt) begin
      n_tests++;
      if (s_addr !== exp_fetch) begin
        n_fail++;
        $display("FAIL req_addr @%0d: got %h expected %h", cyc, s_addr, exp_fetch);
      end
    end
    if (pending.size() > 0 && pending[0].epoch != epoch) begin
      n_tests++;
      if (s_req !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_req @%0d: got %b expected 0", cyc, s_req);
      end
    end
    n_tests++;
    if (pending.size() + buffered > DEPTH) begin
      n_fail++;
      $display("FAIL occupancy @%0d: got %0d expected <= %0d",
               cyc, pending.size() + buffered, DEPTH);
    end
    if (prev_ok && prev_req && !prev_gnt && !prev_redir) begin
      n_tests++;
      if (s_addr !== prev_addr) begin
        n_fail++;
        $display("FAIL addr_hold @%0d: got %h expected %h", cyc, s_addr, prev_addr);
      end
    end
    @(posedge clk);
    cyc++;
    if (s_rvalid && pending.size() > 0) begin
      e = pending.pop_front();
      if (e.epoch == epoch && !s_redir) buffered++;
      else stale_drops++;
    end
    if (s_valid && !s_stall && !s_redir) begin
      buffered--;
      exp_pc += 32'd4;
      consumed++;
    end
    if (s_req && s_gnt) begin
      e.addr = s_addr;
      e.epoch = epoch;
      e.ready = cyc + int'($urandom_range(lat_max, lat_min));
      pending.push_back(e);
      exp_fetch += 32'd4;
    end
    if (s_redir) begin
      epoch++;
      buffered = 0;
      exp_pc = {s_tgt[31:2], 2'b00};
      exp_fetch = exp_pc;
    end
    prev_ok = 1'b1;
    prev_req = s_req;
    prev_gnt = s_gnt;
    prev_redir = s_redir;
    prev_addr = s_addr;
    #1;
    if (pending.size() > 0 && pending[0].ready <= cyc) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i = memf(pending[0].addr);
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i = 32'hDEAD_BEEF;
    end
    imem_gnt_i = (int'($urandom_range(0, 99)) < gnt_pct);
    stall_i = (int'($urandom_range(0, 99)) < stall_pct);
    redirect_i = (int'($urandom_range(0, 99)) < redir_pct);
    redirect_pc_i = $urandom & 32'h0000_0FFF;
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0;
    imem_gnt_i = 1'b1;
    stall_i = 1'b0;
    redirect_i = 1'b0;
    redirect_pc_i = 32'h0;
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (imem_req_o !== 1'b0 || d_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_req_valid: got %b%b expected 00", imem_req_o, d_valid_o);
    end
    n_tests++;
    if (imem_addr_o !== RESET_PC) begin
      n_fail++;
      $display("FAIL reset_addr: got %h expected %h", imem_addr_o, RESET_PC);
    end
    n_tests++;
    if (d_inst_o !== NOP) begin
      n_fail++;
      $display("FAIL reset_inst: got %h expected %h", d_inst_o, NOP);
    end
    n_tests++;
    if (d_pc_o !== RESET_PC) begin
      n_fail++;
      $display("FAIL reset_pc: got %h expected %h", d_pc_o, RESET_PC);
    end
    @(posedge clk);
    #1;
    rst_n_i = 1'b1;
  endtask

  task automatic test_first_fetch();
    int first = -1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (i == 0) begin
        n_tests++;
        if (s_req !== 1'b0) begin
          n_fail++;
          $display("FAIL boot_req: got %b expected 0", s_req);
        end
      end
      if (i == 1) begin
        n_tests++;
        if (s_req !== 1'b1 || s_addr !== RESET_PC) begin
          n_fail++;
          $display("FAIL first_req: got %b/%h expected 1/%h", s_req, s_addr, RESET_PC);
        end
      end
      if (s_valid && first < 0) begin
        first = i;
        n_tests++;
        if (i != FIRST_V || s_pc !== RESET_PC) begin
          n_fail++;
          $display("FAIL first_valid: got cycle %0d pc %h expected cycle %0d pc %h",
                   i, s_pc, FIRST_V, RESET_PC);
        end
      end else if (first >= 0 && i <= first + 2) begin
        n_tests++;
        if (!s_valid || s_pc !== 32'(4 * (i - first))) begin
          n_fail++;
          $display("FAIL back_to_back: got %b/%h expected 1/%h",
                   s_valid, s_pc, 32'(4 * (i - first)));
        end
      end
    end
    n_tests++;
    if (first < 0) begin
      n_fail++;
      $display("FAIL first_valid_timeout: got none expected cycle %0d", FIRST_V);
    end
  endtask

  task automatic test_stall();
    logic [31:0] held = 32'h0;
    stall_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      if (i < 4) stall_i = 1'b1;
      if (i == 0) begin
        held = s_pc;
        n_tests++;
        if (s_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL stall_valid: got %b expected 1", s_valid);
        end
      end else begin
        n_tests++;
        if (!s_valid || s_pc !== held || s_inst !== memf(held)) begin
          n_fail++;
          $display("FAIL stall_frozen: got %h/%h expected %h/%h",
                   s_pc, s_inst, held, memf(held));
        end
      end
    end
    cycle();
    n_tests++;
    if (!s_valid || s_pc !== held) begin
      n_fail++;
      $display("FAIL stall_release: got %h expected %h", s_pc, held);
    end
    cycle();
    n_tests++;
    if (!s_valid || s_pc !== held + 32'd4) begin
      n_fail++;
      $display("FAIL stall_next: got %h expected %h", s_pc, held + 32'd4);
    end
  endtask

  task automatic test_gnt_low();
    gnt_pct = 0;
    repeat (6) cycle();
    n_tests++;
    if (pending.size() != 0) begin
      n_fail++;
      $display("FAIL gnt_drain: got %0d expected 0", pending.size());
    end
    redirect_i = 1'b1;
    redirect_pc_i = 32'h10;
    cycle();
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_tests++;
      if (s_req !== 1'b1 || s_addr !== 32'h10) begin
        n_fail++;
        $display("FAIL gnt_low_hold: got %b/%h expected 1/00000010", s_req, s_addr);
      end
    end
    gnt_pct = 100;
    imem_gnt_i = 1'b1;
    cycle();
    n_tests++;
    if (s_req !== 1'b1 || s_addr !== 32'h10) begin
      n_fail++;
      $display("FAIL gnt_accept: got %b/%h expected 1/00000010", s_req, s_addr);
    end
    cycle();
    n_tests++;
    if (s_addr !== 32'h14) begin
      n_fail++;
      $display("FAIL gnt_advance: got %h expected 00000014", s_addr);
    end
  endtask

  task automatic test_redirect_flush();
    int drops0;
    bit seen_req = 1'b0;
    bit seen_v = 1'b0;
    gnt_pct = 0;
    repeat (4) cycle();
    gnt_pct = 100;
    imem_gnt_i = 1'b1;
    redirect_i = 1'b1;
    redirect_pc_i = 32'h200;
    lat_min = 3;
    lat_max = 3;
    cycle();
    cycle();
    cycle();
    n_tests++;
    if (pending.size() != 2) begin
      n_fail++;
      $display("FAIL flush_setup: got %0d outstanding expected 2", pending.size());
    end
    lat_min = 0;
    lat_max = 0;
    drops0 = stale_drops;
    redirect_i = 1'b1;
    redirect_pc_i = 32'h103;
    cycle();
    for (int i = 0; i < 20 && !seen_v; i++) begin
      cycle();
      if (s_req && !seen_req) begin
        seen_req = 1'b1;
        n_tests++;
        if (s_addr !== 32'h100 || stale_drops - drops0 != 2) begin
          n_fail++;
          $display("FAIL flush_restart: got %h drops %0d expected 00000100 drops 2",
                   s_addr, stale_drops - drops0);
        end
      end
      if (s_valid) begin
        seen_v = 1'b1;
        n_tests++;
        if (s_pc !== 32'h100) begin
          n_fail++;
          $display("FAIL flush_first_pc: got %h expected 00000100", s_pc);
        end
      end
    end
    n_tests++;
    if (!seen_v) begin
      n_fail++;
      $display("FAIL flush_timeout: got no valid expected pc 00000100");
    end
  endtask

  task automatic test_collision();
    bit found = 1'b0;
    bit seen_v = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      cycle();
      if (imem_rvalid_i) found = 1'b1;
    end
    n_tests++;
    if (!found) begin
      n_fail++;
      $display("FAIL collide_setup: got no rvalid expected one");
    end
    stall_i = 1'b1;
    redirect_i = 1'b1;
    redirect_pc_i = 32'h300;
    cycle();
    cycle();
    n_tests++;
    if (s_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL collide_valid: got %b expected 0", s_valid);
    end
    for (int i = 0; i < 8 && !seen_v; i++) begin
      cycle();
      if (s_valid) begin
        seen_v = 1'b1;
        n_tests++;
        if (s_pc !== 32'h300) begin
          n_fail++;
          $display("FAIL collide_pc: got %h expected 00000300", s_pc);
        end
      end
    end
    n_tests++;
    if (!seen_v) begin
      n_fail++;
      $display("FAIL collide_timeout: got no valid expected pc 00000300");
    end
  endtask

  task automatic test_random();
    int c0;
    gnt_pct = 70;
    stall_pct = 30;
    redir_pct = 3;
    lat_min = 0;
    lat_max = 2;
    repeat (1500) cycle();
    gnt_pct = 100;
    stall_pct = 0;
    redir_pct = 0;
    lat_max = 0;
    c0 = consumed;
    repeat (20) cycle();
    n_tests++;
    if (consumed - c0 < 10) begin
      n_fail++;
      $display("FAIL random_drain: got %0d consumed expected >= 10", consumed - c0);
    end
  endtask

  task automatic test_reset_full();
    stall_pct = 100;
    stall_i = 1'b1;
    repeat (6) cycle();
    n_tests++;
    if (s_valid !== 1'b1 || buffered != DEPTH) begin
      n_fail++;
      $display("FAIL full_setup: got valid %b count %0d expected 1 %0d",
               s_valid, buffered, DEPTH);
    end
    rst_n_i = 1'b0;
    #1;
    n_tests++;
    if (imem_req_o !== 1'b0 || d_valid_o !== 1'b0 || d_inst_o !== NOP) begin
      n_fail++;
      $display("FAIL async_reset_out: got %b %b %h expected 0 0 %h",
               imem_req_o, d_valid_o, d_inst_o, NOP);
    end
    n_tests++;
    if (imem_addr_o !== RESET_PC || d_pc_o !== RESET_PC) begin
      n_fail++;
      $display("FAIL async_reset_pc: got %h %h expected %h", imem_addr_o, d_pc_o, RESET_PC);
    end
    reset_model();
    stall_pct = 0;
    stall_i = 1'b0;
    imem_gnt_i = 1'b1;
    redirect_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n_i = 1'b1;
    cycle();
    cycle();
    n_tests++;
    if (s_req !== 1'b1 || s_addr !== RESET_PC) begin
      n_fail++;
      $display("FAIL reset_refetch: got %b/%h expected 1/%h", s_req, s_addr, RESET_PC);
    end
    repeat (6) cycle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_first_fetch();
    test_stall();
    test_gnt_low();
    test_redirect_flush();
    test_collision();
    test_random();
    test_reset_full();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
